// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/memory stall control,
// memory-wait timeout FSM and saturating stall/flush performance counters.
module hazard_unit #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned MEM_TIMEOUT   = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_MemReqM,
  input  logic                     i_MemReadyM,
  output logic [2:0]               o_ForwardAE,
  output logic [2:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_FlushE,
  output logic                     o_MemTimeout,
  output logic [CNT_WIDTH-1:0]     o_StallCycles,
  output logic [CNT_WIDTH-1:0]     o_FlushCycles
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              lwstall, brstall, memstall;

  // Register 0 is hardwired, so it can never create a dependency.
  function automatic logic reg_match(input logic [RF_ADDR_WIDTH-1:0] a,
                                     input logic [RF_ADDR_WIDTH-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    o_ForwardAE = 3'd0;
    if (i_RegWriteM && reg_match(i_WriteRegM, i_RsE))      o_ForwardAE = 3'd2;
    else if (i_RegWriteW && reg_match(i_WriteRegW, i_RsE)) o_ForwardAE = 3'd1;

    o_ForwardBE = 3'd0;
    if (i_RegWriteM && reg_match(i_WriteRegM, i_RtE))      o_ForwardBE = 3'd2;
    else if (i_RegWriteW && reg_match(i_WriteRegW, i_RtE)) o_ForwardBE = 3'd1;

    o_ForwardAD = i_RegWriteM && reg_match(i_WriteRegM, i_RsD);
    o_ForwardBD = i_RegWriteM && reg_match(i_WriteRegM, i_RtD);
  end

  always_comb begin
    lwstall = i_MemtoRegE &&
              (reg_match(i_WriteRegE, i_RsD) || reg_match(i_WriteRegE, i_RtD));
    brstall = i_BranchD &&
              ((i_RegWriteE && (reg_match(i_WriteRegE, i_RsD) || reg_match(i_WriteRegE, i_RtD))) ||
               (i_MemtoRegM && (reg_match(i_WriteRegM, i_RsD) || reg_match(i_WriteRegM, i_RtD))));

    // While reset is asserted the stall logic behaves as if already back in RUN.
    if (!i_rst && state == S_ERROR) memstall = 1'b1;
    else                            memstall = i_MemReqM && !i_MemReadyM;

    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushE = 1'b0;
    if (memstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
    end else if (lwstall || brstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    unique case (state)
      S_RUN: begin
        if (i_MemReqM && !i_MemReadyM) begin
          state_next = S_MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (i_MemReadyM || !i_MemReqM) begin
          state_next = S_RUN;
          wait_next  = '0;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          state_next = S_ERROR;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      S_ERROR: state_next = S_ERROR;
      default: begin
        state_next = S_RUN;
        wait_next  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_RUN;
      wait_cnt      <= '0;
      o_StallCycles <= '0;
      o_FlushCycles <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (o_StallF && (o_StallCycles != '1)) o_StallCycles <= o_StallCycles + CNT_WIDTH'(1);
      if (o_FlushE && (o_FlushCycles != '1)) o_FlushCycles <= o_FlushCycles + CNT_WIDTH'(1);
    end
  end

  assign o_MemTimeout = (state == S_ERROR);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table plus
// multi-cycle sequences for counters, memory wait, timeout and reset.
module tb_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
  logic          rwe, rwm, rww, mre, mrm, br, mreq, mrdy;
  logic [2:0]    fae, fbe;
  logic          fad, fbd, sf, sd, se, sm, fe, tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .RF_ADDR_WIDTH(AW),
    .CNT_WIDTH    (CW),
    .MEM_TIMEOUT  (255)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_RsD        (rsd),
    .i_RtD        (rtd),
    .i_RsE        (rse),
    .i_RtE        (rte),
    .i_WriteRegE  (wre),
    .i_WriteRegM  (wrm),
    .i_WriteRegW  (wrw),
    .i_RegWriteE  (rwe),
    .i_RegWriteM  (rwm),
    .i_RegWriteW  (rww),
    .i_MemtoRegE  (mre),
    .i_MemtoRegM  (mrm),
    .i_BranchD    (br),
    .i_MemReqM    (mreq),
    .i_MemReadyM  (mrdy),
    .o_ForwardAE  (fae),
    .o_ForwardBE  (fbe),
    .o_ForwardAD  (fad),
    .o_ForwardBD  (fbd),
    .o_StallF     (sf),
    .o_StallD     (sd),
    .o_StallE     (se),
    .o_StallM     (sm),
    .o_FlushE     (fe),
    .o_MemTimeout (tmo),
    .o_StallCycles(stall_cnt),
    .o_FlushCycles(flush_cnt)
  );

  typedef struct {
    logic [AW-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic          rwe, rwm, rww, mre, mrm, br;
    logic [7:0]    exp_fwd;  // {ForwardAE, ForwardBE, ForwardAD, ForwardBD}
    logic [4:0]    exp_stl;  // {StallF, StallD, StallE, StallM, FlushE}
  } vec_t;

  vec_t vq[$];

  task automatic add(input int a_rsd, input int a_rtd, input int a_rse, input int a_rte,
                     input int a_wre, input int a_wrm, input int a_wrw,
                     input bit a_rwe, input bit a_rwm, input bit a_rww,
                     input bit a_mre, input bit a_mrm, input bit a_br,
                     input int e_fae, input int e_fbe, input bit e_fad, input bit e_fbd,
                     input logic [4:0] e_stl);
    vec_t v;
    v.rsd = AW'(a_rsd); v.rtd = AW'(a_rtd); v.rse = AW'(a_rse); v.rte = AW'(a_rte);
    v.wre = AW'(a_wre); v.wrm = AW'(a_wrm); v.wrw = AW'(a_wrw);
    v.rwe = a_rwe; v.rwm = a_rwm; v.rww = a_rww;
    v.mre = a_mre; v.mrm = a_mrm; v.br = a_br;
    v.exp_fwd = {3'(e_fae), 3'(e_fbe), e_fad, e_fbd};
    v.exp_stl = e_stl;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    {rsd, rtd, rse, rte, wre, wrm, wrw} = '0;
    {rwe, rwm, rww, mre, mrm, br, mreq, mrdy} = '0;
  endtask

  task automatic apply(input vec_t v);
    rsd = v.rsd; rtd = v.rtd; rse = v.rse; rte = v.rte;
    wre = v.wre; wrm = v.wrm; wrw = v.wrw;
    rwe = v.rwe; rwm = v.rwm; rww = v.rww;
    mre = v.mre; mrm = v.mrm; br = v.br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] stalls();
    return {sf, sd, se, sm, fe};
  endfunction

  initial begin
    logic early;
    rst = 1'b1;
    idle();

    //   rsd rtd rse rte wre wrm wrw  rwe rwm rww mre mrm br   fae fbe fad fbd stl
    add( 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  5'b00000);
    add( 0,  0,  8,  0,  0,  8,  8,  0,  1,  1,  0,  0,  0,   2,  0,  0,  0,  5'b00000);
    add( 0,  0,  8,  0,  0,  9,  8,  0,  1,  1,  0,  0,  0,   1,  0,  0,  0,  5'b00000);
    add( 0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  0,   0,  0,  0,  0,  5'b00000);
    add( 0,  0,  4,  3,  0,  3,  4,  0,  1,  1,  0,  0,  0,   1,  2,  0,  0,  5'b00000);
    add( 0,  0,  0,  7,  0,  7,  7,  0,  0,  1,  0,  0,  0,   0,  1,  0,  0,  5'b00000);
    add(10, 11,  0,  0,  0, 10,  0,  0,  1,  0,  0,  0,  0,   0,  0,  1,  0,  5'b00000);
    add(12, 11,  0,  0,  0, 11,  0,  0,  1,  0,  0,  0,  0,   0,  0,  0,  1,  5'b00000);
    add( 0,  5,  0,  0,  5,  0,  0,  0,  0,  0,  1,  0,  0,   0,  0,  0,  0,  5'b11001);
    add( 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,   0,  0,  0,  0,  5'b00000);
    add( 6,  0,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0,  1,   0,  0,  0,  0,  5'b11001);
    add( 0,  7,  0,  0,  0,  7,  0,  0,  0,  0,  0,  1,  1,   0,  0,  0,  0,  5'b11001);
    add( 1,  2,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0,  1,   0,  0,  0,  0,  5'b00000);
    add( 6,  0,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0,  0,   0,  0,  0,  0,  5'b00000);
    add( 0,  7,  0,  0,  0,  7,  0,  0,  1,  0,  0,  1,  1,   0,  0,  0,  1,  5'b11001);
    add( 0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,  1,   0,  0,  0,  0,  5'b00000);
    add( 0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  1,   0,  0,  0,  0,  5'b00000);

    do_reset();
    #1;
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    check("reset_timeout",   32'(tmo), 0);

    foreach (vq[i]) begin
      @(negedge clk);
      apply(vq[i]);
      #1;
      check($sformatf("vec%0d_fwd", i), 32'(fae) << 5 | 32'(fbe) << 2 | 32'(fad) << 1 | 32'(fbd),
            32'(vq[i].exp_fwd));
      check($sformatf("vec%0d_stall", i), 32'(stalls()), 32'(vq[i].exp_stl));
    end

    // Load-use stall for one cycle: both counters advance by one.
    do_reset();
    idle();
    mre = 1'b1; wre = 5; rtd = 5;
    #1;
    check("lw_stall", 32'(stalls()), 32'b11001);
    step();
    check("lw_stall_cnt", 32'(stall_cnt), 1);
    check("lw_flush_cnt", 32'(flush_cnt), 1);

    // Memory stall overrides load-use; ready wins in the same cycle.
    do_reset();
    mreq = 1'b1; mrdy = 1'b0;
    #1;
    check("memstall_run", 32'(stalls()), 32'b11110);
    step();
    check("memstall_wait", 32'(stalls()), 32'b11110);
    check("memstall_flush_cnt", 32'(flush_cnt), 0);
    @(negedge clk);
    mrdy = 1'b1;
    #1;
    check("ready_wins", 32'(stalls()), 32'b11001);
    step();
    @(negedge clk);
    idle();
    #1;
    check("back_to_run", 32'(stalls()), 32'b00000);
    check("back_to_run_tmo", 32'(tmo), 0);

    // Dropping the request mid-wait clears the wait counter.
    do_reset();
    idle();
    mreq = 1'b1;
    for (int i = 0; i < 100; i++) step();
    @(negedge clk);
    mreq = 1'b0;
    step();
    @(negedge clk);
    mreq = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (tmo) early = 1'b1;
    end
    check("wait_cleared_no_early_tmo", 32'(early), 0);
    step();
    check("wait_cleared_tmo", 32'(tmo), 1);

    // Full timeout: 256 edges of waiting reach ERROR, held until reset.
    do_reset();
    idle();
    mreq = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (tmo) early = 1'b1;
    end
    check("tmo_not_early", 32'(early), 0);
    step();
    check("tmo_set", 32'(tmo), 1);
    check("tmo_stalls", 32'(stalls()), 32'b11110);
    @(negedge clk);
    mrdy = 1'b1;
    #1;
    check("error_ready_stalls", 32'(stalls()), 32'b11110);
    step();
    check("error_held", 32'(tmo), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_reset_stalls", 32'(stalls()), 32'b00000);
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_reset_tmo", 32'(tmo), 0);
    check("after_reset_stalls", 32'(stalls()), 32'b00000);

    // Counter saturation with a 4-bit counter.
    do_reset();
    idle();
    mre = 1'b1; wre = 3; rsd = 3;
    for (int i = 0; i < 14; i++) step();
    check("sat_cnt_14", 32'(stall_cnt), 14);
    step();
    check("sat_cnt_15", 32'(stall_cnt), 15);
    step();
    step();
    check("sat_stall_hold", 32'(stall_cnt), 15);
    check("sat_flush_hold", 32'(flush_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
